blink_sequencer: RTL and testbench
==================================

Name: blink_sequencer

Overview:
- Controller that sequences the LED counter datapath.
- A programmable prescaler generates the pattern tick. A run/pause/apply state machine selects one of four LED patterns and applies speed/mode configuration through a valid/ready handshake.
- Sits between the ui_in control pins and uo_out, replacing the free-running fixed-rate counter.

Parameters:
- TICK_W, 25, prescaler counter width.
- DEFAULT_RELOAD, 24999999, prescaler terminal count at speed 0; tick period = reload+1 cycles.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- run  in  1  level; 1 = advance pattern, 0 = pause
- cfg_valid  in  1  configuration request
- cfg_mode  in  2  0=count up, 1=count down, 2=rotate left, 3=bounce
- cfg_speed  in  3  prescaler shift: reload = DEFAULT_RELOAD >> cfg_speed
- cfg_ready  out  1  configuration accepted when cfg_valid & cfg_ready
- led  out  8  pattern output (drives uo_out)
- tick  out  1  one-cycle pulse on every pattern advance
- wrap  out  1  one-cycle pulse when the pattern returns to its load value
- state  out  2  0=IDLE, 1=RUN, 2=PAUSE, 3=APPLY

Behaviour:
- Reset, sampled on the clk edge only:
  - state=IDLE, mode=0, speed=0, prescaler cnt=0.
  - led=8'h00, tick=0, wrap=0, bounce direction=left.
- cfg_ready is combinational: 1 in IDLE/RUN/PAUSE, 0 in APPLY. It is 1 in the first cycle after reset.
- FSM:
  - IDLE -> RUN when run=1.
  - RUN -> PAUSE when run=0.
  - PAUSE -> RUN when run=1.
  - Any non-APPLY state -> APPLY on a handshake. The handshake has priority over run transitions.
  - APPLY lasts exactly 1 cycle, then goes to RUN if run=1, else PAUSE. IDLE is re-entered only via rst.
- Handshake edge: mode/speed are latched, cnt<=0, led<=load value, direction<=left.
  - Load values: up 8'h00, down 8'hFF, rotate 8'h01, bounce 8'h01.
  - A cfg_valid held during APPLY is ignored until cfg_ready returns to 1.
- Prescaler, RUN only:
  - If cnt == (DEFAULT_RELOAD >> speed): cnt<=0, led advances, tick<=1.
  - Otherwise cnt<=cnt+1 and tick<=0.
  - A shifted reload of 0 means one tick per cycle.
  - In IDLE/PAUSE/APPLY, cnt and led hold and tick=0. Resuming from PAUSE continues from the held cnt.
- Pattern advance, 8-bit, wrap modulo 256:
  - up: led+1; wrap when FF->00.
  - down: led-1; wrap when 00->FF.
  - rotate: {led[6:0],led[7]}; wrap when 80->01.
  - bounce: one-hot shift in the current direction.
    - At 8'h80 the direction flips to right and the same advance produces 8'h40.
    - At 8'h01 moving right, the direction flips to left and the advance produces 8'h02.
    - wrap pulses when led becomes 8'h01 (02->01).
- tick and wrap are registered and change on the same edge as led. wrap is only ever asserted together with tick.
- Simultaneous handshake and terminal count: the handshake wins. No advance occurs, tick=0, wrap=0, and led=new load value.
- rst mid-operation, in any state including APPLY: all state returns to reset values on that edge. Any in-flight configuration is discarded.
- Changing run during APPLY only affects the exit target.

Test Plan:
- DEFAULT_RELOAD=9, rst 1 cycle, run=1, no cfg:
  - State goes IDLE->RUN; tick every 10 cycles.
  - led 00,01,02,...; the 256th tick gives led=00 with wrap=1.
- While running, handshake mode=2, speed=1:
  - cfg_ready=0 for exactly 1 cycle, state=3 for that cycle, led=01.
  - Then ticks every 5 cycles: 02,04,...,80,01; wrap on 01.
- mode=3, speed=0:
  - led sequence 01,02,...,80,40,...,02,01.
  - wrap pulses exactly on the 14th tick.
  - No other wrap pulses.
- run=0 when cnt=6:
  - state=PAUSE, led/cnt frozen for 20 cycles, tick=0.
  - Restore run=1: next tick 4 cycles after re-entering RUN.
- Stall and edge cases:
  - Assert cfg_valid on the same cycle cnt==reload: no tick, led=load value.
  - Then speed=7 (9>>7=0): tick every RUN cycle.
  - mode=1 from 00: FF with wrap.
- rst pulsed during APPLY and during RUN:
  - Next edge: state=IDLE, led=00, tick=0, wrap=0, cfg_ready=1, mode back to count up.

Source files
------------

// File: rtl/blink_sequencer.sv
// Blink sequencer: prescaled LED pattern generator with a run/pause/apply FSM
// and a valid/ready configuration port for pattern mode and speed.
module blink_sequencer #(
    parameter int unsigned TICK_W         = 25,
    parameter int unsigned DEFAULT_RELOAD = 24999999
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       run,
    input  logic       cfg_valid,
    input  logic [1:0] cfg_mode,
    input  logic [2:0] cfg_speed,
    output logic       cfg_ready,
    output logic [7:0] led,
    output logic       tick,
    output logic       wrap,
    output logic [1:0] state
);

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StRun   = 2'd1,
        StPause = 2'd2,
        StApply = 2'd3
    } state_e;

    localparam logic [TICK_W-1:0] BaseReload = TICK_W'(DEFAULT_RELOAD);

    state_e            st;
    logic [1:0]        mode;
    logic [2:0]        speed;
    logic [TICK_W-1:0] cnt;
    logic              dir_right;

    logic [TICK_W-1:0] reload;
    logic              handshake;
    logic [7:0]        load_val;
    logic [7:0]        led_next;
    logic              dir_next;
    logic              wrap_next;

    assign cfg_ready = (st != StApply);
    assign handshake = cfg_valid & cfg_ready;
    assign reload    = BaseReload >> speed;
    assign state     = st;

    always_comb begin
        case (cfg_mode)
            2'd0:    load_val = 8'h00;
            2'd1:    load_val = 8'hFF;
            default: load_val = 8'h01;
        endcase
    end

    // Next pattern value; bounce reverses at either end within the same advance.
    always_comb begin
        led_next  = led;
        dir_next  = dir_right;
        wrap_next = 1'b0;
        case (mode)
            2'd0: begin
                led_next  = led + 8'd1;
                wrap_next = (led == 8'hFF);
            end
            2'd1: begin
                led_next  = led - 8'd1;
                wrap_next = (led == 8'h00);
            end
            2'd2: begin
                led_next  = {led[6:0], led[7]};
                wrap_next = (led == 8'h80);
            end
            default: begin
                if (!dir_right) begin
                    if (led == 8'h80) begin
                        led_next = 8'h40;
                        dir_next = 1'b1;
                    end else begin
                        led_next = led << 1;
                    end
                end else begin
                    if (led == 8'h01) begin
                        led_next = 8'h02;
                        dir_next = 1'b0;
                    end else begin
                        led_next = led >> 1;
                    end
                end
                wrap_next = (led_next == 8'h01);
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            st        <= StIdle;
            mode      <= 2'd0;
            speed     <= 3'd0;
            cnt       <= '0;
            led       <= 8'h00;
            tick      <= 1'b0;
            wrap      <= 1'b0;
            dir_right <= 1'b0;
        end else begin
            tick <= 1'b0;
            wrap <= 1'b0;
            // A handshake pre-empts both run transitions and a coincident terminal count.
            if (handshake) begin
                st        <= StApply;
                mode      <= cfg_mode;
                speed     <= cfg_speed;
                cnt       <= '0;
                led       <= load_val;
                dir_right <= 1'b0;
            end else begin
                case (st)
                    StIdle: begin
                        if (run) st <= StRun;
                    end
                    StRun: begin
                        if (!run) st <= StPause;
                        if (cnt == reload) begin
                            cnt       <= '0;
                            led       <= led_next;
                            dir_right <= dir_next;
                            tick      <= 1'b1;
                            wrap      <= wrap_next;
                        end else begin
                            cnt <= cnt + TICK_W'(1);
                        end
                    end
                    StPause: begin
                        if (run) st <= StRun;
                    end
                    default: begin
                        st <= run ? StRun : StPause;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_blink_sequencer.sv
// Bench for blink_sequencer: per-cycle scoreboard against a behavioural model,
// plus directed checks of the documented sequences and corner cases.
module tb_blink_sequencer;

    localparam int RELOAD = 9;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       run = 1'b0;
    logic       cfg_valid = 1'b0;
    logic [1:0] cfg_mode = 2'd0;
    logic [2:0] cfg_speed = 3'd0;
    logic       cfg_ready;
    logic [7:0] led;
    logic       tick;
    logic       wrap;
    logic [1:0] state;

    blink_sequencer #(
        .TICK_W        (25),
        .DEFAULT_RELOAD(RELOAD)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .run      (run),
        .cfg_valid(cfg_valid),
        .cfg_mode (cfg_mode),
        .cfg_speed(cfg_speed),
        .cfg_ready(cfg_ready),
        .led      (led),
        .tick     (tick),
        .wrap     (wrap),
        .state    (state)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0] st;
        logic [7:0] led;
        logic       tick;
        logic       wrap;
        logic       rdy;
    } exp_t;

    exp_t sb[$];
    int n_cmp = 0;
    int n_err = 0;
    int n_tick = 0;
    int n_wrap = 0;

    int m_st = 0, m_mode = 0, m_speed = 0, m_cnt = 0, m_led = 0;
    bit m_right = 0, m_tick = 0, m_wrap = 0;

    task automatic cmp(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic advance();
        case (m_mode)
            0: begin m_wrap = (m_led == 255); m_led = (m_led + 1) % 256; end
            1: begin m_wrap = (m_led == 0); m_led = (m_led + 255) % 256; end
            2: begin m_wrap = (m_led == 128); m_led = ((m_led * 2) % 256) | (m_led / 128); end
            default: begin
                if (!m_right && m_led == 128) m_right = 1;
                else if (m_right && m_led == 1) m_right = 0;
                m_led  = m_right ? m_led / 2 : m_led * 2;
                m_wrap = (m_led == 1);
            end
        endcase
    endtask

    task automatic model_step();
        bit hs;
        hs = cfg_valid && (m_st != 3);
        m_tick = 0;
        m_wrap = 0;
        if (rst) begin
            m_st = 0; m_mode = 0; m_speed = 0; m_cnt = 0; m_led = 0; m_right = 0;
        end else if (hs) begin
            m_st = 3; m_mode = int'(cfg_mode); m_speed = int'(cfg_speed);
            m_cnt = 0; m_right = 0;
            m_led = (cfg_mode == 2'd0) ? 0 : (cfg_mode == 2'd1) ? 255 : 1;
        end else begin
            if (m_st == 1) begin
                if (m_cnt == (RELOAD >> m_speed)) begin
                    m_cnt = 0; m_tick = 1; advance();
                end else begin
                    m_cnt++;
                end
            end
            case (m_st)
                0: if (run) m_st = 1;
                1: if (!run) m_st = 2;
                2: if (run) m_st = 1;
                default: m_st = run ? 1 : 2;
            endcase
        end
    endtask

    // Advance n clock cycles; the model's prediction is queued before each edge.
    task automatic cyc(input int n);
        exp_t e;
        exp_t g;
        for (int i = 0; i < n; i++) begin
            model_step();
            e.st = 2'(m_st); e.led = 8'(m_led); e.tick = m_tick; e.wrap = m_wrap;
            e.rdy = (m_st != 3);
            sb.push_back(e);
            @(posedge clk);
            #1;
            g = sb.pop_front();
            cmp("sb_state", 32'(state), 32'(g.st));
            cmp("sb_led", 32'(led), 32'(g.led));
            cmp("sb_tick", 32'(tick), 32'(g.tick));
            cmp("sb_wrap", 32'(wrap), 32'(g.wrap));
            cmp("sb_ready", 32'(cfg_ready), 32'(g.rdy));
            n_tick += int'(tick);
            n_wrap += int'(wrap);
        end
    endtask

    initial begin
        // Reset and free run in count-up mode
        rst = 1'b1; cyc(1);
        cmp("rst_state", 32'(state), 0); cmp("rst_led", 32'(led), 0);
        cmp("rst_ready", 32'(cfg_ready), 1); cmp("rst_tick", 32'(tick), 0);
        cmp("rst_wrap", 32'(wrap), 0);
        rst = 1'b0; run = 1'b1; cyc(1);
        cmp("idle_to_run", 32'(state), 1);
        n_tick = 0; n_wrap = 0; cyc(10);
        cmp("first_tick", 32'(tick), 1); cmp("first_led", 32'(led), 1);
        cyc(2550);
        cmp("up256_led", 32'(led), 0); cmp("up256_wrap", 32'(wrap), 1);
        cmp("up256_ticks", 32'(n_tick), 256); cmp("up256_wraps", 32'(n_wrap), 1);

        // Rotate, speed 1
        cfg_valid = 1'b1; cfg_mode = 2'd2; cfg_speed = 3'd1; cyc(1);
        cmp("rot_apply_state", 32'(state), 3); cmp("rot_apply_ready", 32'(cfg_ready), 0);
        cmp("rot_apply_led", 32'(led), 1);
        cfg_valid = 1'b0; cyc(1);
        cmp("rot_run_state", 32'(state), 1); cmp("rot_run_ready", 32'(cfg_ready), 1);
        n_tick = 0; n_wrap = 0; cyc(5);
        cmp("rot_first_tick", 32'(tick), 1); cmp("rot_first_led", 32'(led), 2);
        cyc(35);
        cmp("rot_wrap_led", 32'(led), 1); cmp("rot_wrap", 32'(wrap), 1);
        cmp("rot_ticks", 32'(n_tick), 8); cmp("rot_wraps", 32'(n_wrap), 1);

        // Bounce, speed 0
        cfg_valid = 1'b1; cfg_mode = 2'd3; cfg_speed = 3'd0; cyc(1);
        cfg_valid = 1'b0; cyc(1);
        n_tick = 0; n_wrap = 0; cyc(130);
        cmp("bnc_13_led", 32'(led), 2); cmp("bnc_13_wraps", 32'(n_wrap), 0);
        cyc(10);
        cmp("bnc_14_led", 32'(led), 1); cmp("bnc_14_wrap", 32'(wrap), 1);
        cmp("bnc_14_ticks", 32'(n_tick), 14);
        cyc(30);
        cmp("bnc_17_led", 32'(led), 8); cmp("bnc_17_wraps", 32'(n_wrap), 1);

        // Pause with the prescaler part-way through a period
        cyc(6);
        run = 1'b0; cyc(1);
        cmp("pause_state", 32'(state), 2);
        n_tick = 0; cyc(20);
        cmp("pause_hold_state", 32'(state), 2); cmp("pause_hold_led", 32'(led), 8);
        cmp("pause_no_tick", 32'(n_tick), 0);
        run = 1'b1; cyc(3);
        cmp("resume_state", 32'(state), 1); cmp("resume_early", 32'(n_tick), 0);
        cyc(1);
        cmp("resume_tick", 32'(tick), 1); cmp("resume_led", 32'(led), 8'h10);

        // Handshake on terminal count, then cfg_valid held through APPLY
        cyc(9);
        cfg_valid = 1'b1; cfg_mode = 2'd0; cfg_speed = 3'd7; cyc(1);
        cmp("tc_hs_state", 32'(state), 3); cmp("tc_hs_tick", 32'(tick), 0);
        cmp("tc_hs_led", 32'(led), 0); cmp("tc_hs_wrap", 32'(wrap), 0);
        cfg_mode = 2'd1; cfg_speed = 3'd0; cyc(1);
        cmp("held_valid_state", 32'(state), 1); cmp("held_valid_led", 32'(led), 0);
        cfg_valid = 1'b0; cyc(1);
        cmp("fast_tick1", 32'(tick), 1); cmp("fast_led1", 32'(led), 1);
        cyc(1);
        cmp("fast_tick2", 32'(tick), 1); cmp("fast_led2", 32'(led), 2);

        // Count down at one tick per cycle
        cfg_valid = 1'b1; cfg_mode = 2'd1; cfg_speed = 3'd7; cyc(1);
        cmp("down_load", 32'(led), 8'hFF);
        cfg_valid = 1'b0; cyc(1);
        n_tick = 0; n_wrap = 0; cyc(255);
        cmp("down_zero", 32'(led), 0); cmp("down_nowrap", 32'(n_wrap), 0);
        cmp("down_ticks", 32'(n_tick), 255);
        cyc(1);
        cmp("down_wrap_led", 32'(led), 8'hFF); cmp("down_wrap", 32'(wrap), 1);

        // APPLY exits to PAUSE when run is low
        cfg_valid = 1'b1; cfg_mode = 2'd0; cfg_speed = 3'd0; cyc(1);
        cfg_valid = 1'b0; run = 1'b0; cyc(1);
        cmp("apply_to_pause", 32'(state), 2);
        run = 1'b1; cyc(1);
        cmp("pause_to_run", 32'(state), 1);

        // Reset during APPLY discards the pending configuration
        cfg_valid = 1'b1; cfg_mode = 2'd2; cfg_speed = 3'd3; cyc(1);
        cmp("pre_rst_apply", 32'(state), 3);
        cfg_valid = 1'b0; rst = 1'b1; cyc(1);
        cmp("rsta_state", 32'(state), 0); cmp("rsta_led", 32'(led), 0);
        cmp("rsta_tick", 32'(tick), 0); cmp("rsta_wrap", 32'(wrap), 0);
        cmp("rsta_ready", 32'(cfg_ready), 1);
        rst = 1'b0; cyc(1);
        n_tick = 0; cyc(10);
        cmp("rsta_mode_up", 32'(led), 1); cmp("rsta_tick_after", 32'(tick), 1);

        // Reset during RUN wins over a simultaneous request
        cyc(5);
        rst = 1'b1; cfg_valid = 1'b1; cfg_mode = 2'd3; cyc(1);
        cmp("rstr_state", 32'(state), 0); cmp("rstr_led", 32'(led), 0);
        cmp("rstr_tick", 32'(tick), 0); cmp("rstr_wrap", 32'(wrap), 0);
        cmp("rstr_ready", 32'(cfg_ready), 1);
        rst = 1'b0; cfg_valid = 1'b0; cyc(1);
        cmp("rstr_run", 32'(state), 1);
        cyc(10);
        cmp("rstr_mode_up", 32'(led), 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
